// File: rtl/alu_exec_seq_if.sv
// Handshake and data bundle between the control unit and the sequenced ALU.
// The master side launches operations; the slave side is the ALU itself.
interface alu_exec_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       opAlu;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [2:0]       sinal_ula;

    modport master (
        output start, opAlu, a, b,
        input  busy, done, result, zero, illegal, sinal_ula
    );

    modport slave (
        input  start, opAlu, a, b,
        output busy, done, result, zero, illegal, sinal_ula
    );
endinterface

// File: rtl/alu_exec_seq.sv
// Sequenced ALU execution unit: single-cycle logic/arithmetic ops plus a
// multi-cycle shift-add multiplier whose upper half lands in a HI register
// that MF reads back. Operands are captured on an accepted start and the
// result, flags and decoded select are held until the next completion.
module alu_exec_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          reset,
    alu_exec_seq_if.slave bus
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MF  = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } stateT;

    stateT              state;
    stateT              nextState;

    logic [2:0]         opReg;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [2:0]         sinalReg;

    logic [WIDTH-1:0]   resultReg;
    logic               zeroReg;
    logic               illegalReg;
    logic [WIDTH-1:0]   hiReg;

    logic               mulRun;
    logic [CNT_W-1:0]   mulCount;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] accNext;
    logic               mulLast;

    logic [WIDTH-1:0]   execValue;
    logic               accept;

    // Map the control unit's op code onto the ALU select lines.
    function automatic logic [2:0] decodeOp(input logic [2:0] op);
        logic [2:0] sel;
        case (op)
            OP_AND:  sel = 3'b000;
            OP_OR:   sel = 3'b001;
            OP_ADD:  sel = 3'b010;
            OP_SUB:  sel = 3'b110;
            OP_SLT:  sel = 3'b111;
            OP_MUL:  sel = 3'b011;
            OP_MF:   sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    assign accept  = (state == IDLE) && bus.start;
    assign mulLast = mulRun && (mulCount == LAST_ITER);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: MUL takes one clear cycle plus WIDTH iterations.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = (bus.opAlu == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC:    nextState = DONE;
            MUL: begin
                if (mulLast) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs follow the state; data outputs come from held registers.
    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.result    = resultReg;
        bus.zero      = zeroReg;
        bus.illegal   = illegalReg;
        bus.sinal_ula = sinalReg;
        case (state)
            IDLE:    bus.busy = 1'b0;
            EXEC:    bus.busy = 1'b1;
            MUL:     bus.busy = 1'b1;
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: bus.busy = 1'b0;
        endcase
    end

    // Capture op and operands only on an accepted start so busy-time starts are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            opReg    <= '0;
            aReg     <= '0;
            bReg     <= '0;
            sinalReg <= '0;
        end else if (accept) begin
            opReg    <= bus.opAlu;
            aReg     <= bus.a;
            bReg     <= bus.b;
            sinalReg <= decodeOp(bus.opAlu);
        end
    end

    // Single-cycle datapath; carries and overflow simply fall off the top.
    always_comb begin
        execValue = '0;
        case (opReg)
            OP_AND:  execValue = aReg & bReg;
            OP_OR:   execValue = aReg | bReg;
            OP_ADD:  execValue = aReg + bReg;
            OP_SUB:  execValue = aReg - bReg;
            OP_SLT:  execValue = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(bReg))};
            OP_MF:   execValue = hiReg;
            OP_ILL:  execValue = '0;
            default: execValue = '0;
        endcase
    end

    // Accumulator value after the current shift-add step.
    always_comb begin
        accNext = acc;
        if (mplier[0]) begin
            accNext = acc + mcand;
        end
    end

    // Shift-add multiplier: first MUL cycle clears/loads, then one bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mulRun   <= 1'b0;
            mulCount <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else if (accept) begin
            mulRun   <= 1'b0;
            mulCount <= '0;
        end else if (state == MUL) begin
            if (!mulRun) begin
                mulRun   <= 1'b1;
                mulCount <= '0;
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, aReg};
                mplier   <= bReg;
            end else begin
                acc      <= accNext;
                mcand    <= mcand << 1;
                mplier   <= mplier >> 1;
                mulCount <= mulCount + 1'b1;
            end
        end
    end

    // Result, flags and HI update on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            resultReg  <= '0;
            zeroReg    <= 1'b0;
            illegalReg <= 1'b0;
            hiReg      <= '0;
        end else if (state == EXEC) begin
            resultReg  <= execValue;
            zeroReg    <= (execValue == '0);
            illegalReg <= (opReg == OP_ILL);
        end else if ((state == MUL) && mulLast) begin
            resultReg  <= accNext[WIDTH-1:0];
            hiReg      <= accNext[2*WIDTH-1:WIDTH];
            zeroReg    <= (accNext[WIDTH-1:0] == '0);
            illegalReg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for the sequenced ALU: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_alu_exec_seq;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_exec_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural model state: cycles left until idle plus the visible outputs.
    bit               modelValid = 0;
    int               mRemain = 0;
    logic [2:0]       pendOp;
    logic [WIDTH-1:0] pendA, pendB;
    logic [WIDTH-1:0] mResult, mHi;
    logic             mZero, mIll;
    logic [2:0]       mSinal;

    logic [2:0] sinalTable [8] = '{3'b000, 3'b001, 3'b010, 3'b110,
                                   3'b111, 3'b011, 3'b100, 3'b000};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update: latency is 2 cycles (EXEC+DONE) or WIDTH+2 for MUL.
    always @(posedge clk) begin
        logic [2*WIDTH-1:0] prod;
        if (reset) begin
            modelValid = 1;
            mRemain    = 0;
            mResult    = '0;
            mZero      = 1'b0;
            mIll       = 1'b0;
            mSinal     = '0;
            mHi        = '0;
        end else if (mRemain == 0) begin
            if (bus.start) begin
                pendOp  = bus.opAlu;
                pendA   = bus.a;
                pendB   = bus.b;
                mSinal  = sinalTable[bus.opAlu];
                mRemain = (bus.opAlu == 3'b101) ? WIDTH + 2 : 2;
            end
        end else begin
            mRemain--;
            if (mRemain == 1) begin
                mIll = 1'b0;
                case (pendOp)
                    3'd0: mResult = pendA & pendB;
                    3'd1: mResult = pendA | pendB;
                    3'd2: mResult = WIDTH'(int'(pendA) + int'(pendB));
                    3'd3: mResult = WIDTH'(int'(pendA) - int'(pendB));
                    3'd4: mResult = ($signed(pendA) < $signed(pendB)) ? WIDTH'(1) : WIDTH'(0);
                    3'd5: begin
                        prod    = (2*WIDTH)'(pendA) * (2*WIDTH)'(pendB);
                        mResult = prod[WIDTH-1:0];
                        mHi     = prod[2*WIDTH-1:WIDTH];
                    end
                    3'd6: mResult = mHi;
                    default: begin
                        mResult = '0;
                        mIll    = 1'b1;
                    end
                endcase
                mZero = (mResult == '0);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("busy", bus.busy, mRemain > 0);
            checkOutput("done", bus.done, mRemain == 1);
            checkOutput("result", bus.result, mResult);
            checkOutput("zero", bus.zero, mZero);
            checkOutput("illegal", bus.illegal, mIll);
            checkOutput("sinal_ula", bus.sinal_ula, mSinal);
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        bus.start = 1'b1;
        bus.opAlu = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Launch one op from idle and check latency plus literal results at done.
    task automatic runOp(input string name, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit hold, input int expLat,
                         input logic [WIDTH-1:0] expRes, input logic expZero,
                         input logic expIll, input logic [2:0] expSinal);
        int lat;
        bit seen;
        applyStimulus(op, a, b);
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        lat  = 1;
        seen = 0;
        while (!seen && lat <= 40) begin
            if (bus.done === 1'b1) begin
                seen = 1;
            end else begin
                if (hold) begin
                    bus.opAlu = 3'($urandom);
                    bus.a     = WIDTH'($urandom);
                    bus.b     = WIDTH'($urandom);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        bus.start = 1'b0;
        checkOutput({name, " done seen"}, seen, 1);
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " result"}, bus.result, expRes);
        checkOutput({name, " model result"}, mResult, expRes);
        checkOutput({name, " zero"}, bus.zero, expZero);
        checkOutput({name, " illegal"}, bus.illegal, expIll);
        checkOutput({name, " sinal_ula"}, bus.sinal_ula, expSinal);
        @(posedge clk); #1;
        checkOutput({name, " done pulse ends"}, bus.done, 0);
        checkOutput({name, " idle after"}, bus.busy, 0);
        checkOutput({name, " result held"}, bus.result, expRes);
    endtask

    initial begin
        int doneSeen;
        logic [WIDTH-1:0] corner [4];
        corner = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        bus.start = 1'b0;
        bus.opAlu = '0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset result", bus.result, 0);
        checkOutput("reset zero", bus.zero, 0);
        checkOutput("reset illegal", bus.illegal, 0);
        checkOutput("reset sinal_ula", bus.sinal_ula, 0);

        runOp("ADD", 3'b010, 8'hF0, 8'h20, 0, 2, 8'h10, 0, 0, 3'b010);
        runOp("SUB", 3'b011, 8'h05, 8'h05, 0, 2, 8'h00, 1, 0, 3'b110);
        runOp("SLT", 3'b100, 8'hFF, 8'h01, 0, 2, 8'h01, 0, 0, 3'b111);
        runOp("MUL", 3'b101, 8'hC8, 8'h0A, 0, 10, 8'hD0, 0, 0, 3'b011);
        runOp("MF", 3'b110, 8'h00, 8'h00, 0, 2, 8'h07, 0, 0, 3'b100);
        runOp("MUL held start", 3'b101, 8'hC8, 8'h0A, 1, 10, 8'hD0, 0, 0, 3'b011);

        // Reset four cycles into a MUL: abort, no done, HI cleared.
        applyStimulus(3'b101, 8'h33, 8'h44);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort busy", bus.busy, 0);
        checkOutput("abort done", bus.done, 0);
        doneSeen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) doneSeen++;
        end
        checkOutput("abort no done", doneSeen, 0);
        runOp("MF after abort", 3'b110, 8'h12, 8'h34, 0, 2, 8'h00, 1, 0, 3'b100);

        runOp("ILLEGAL", 3'b111, 8'hAA, 8'h55, 0, 2, 8'h00, 1, 1, 3'b000);
        runOp("AND", 3'b000, 8'h0F, 8'h3C, 0, 2, 8'h0C, 0, 0, 3'b000);

        // Randomized traffic, including held starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) != 0);
            bus.opAlu = ($urandom_range(0, 3) == 0) ? 3'b101 : 3'($urandom);
            bus.a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
            bus.b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
            reset     = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (WIDTH + 4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Bound the run in case the design never settles.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
